// File: rtl/cpu_readpath.sv
// cpu_readpath: in-order load-return queue feeding mem_dest/mem_result to COM.
// Optional same-cycle bypass of returning data: define CPU_READPATH_BYPASS_EN.
module cpu_readpath #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [4:0]  ld_dest,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    input  logic [1:0]  ld_addr_lo,
    output logic        ld_full,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        mem_ready,
    output logic [4:0]  mem_dest,
    output logic [31:0] mem_result,
    output logic        mem_pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]       e_dest   [DEPTH];
    logic [1:0]       e_size   [DEPTH];
    logic             e_signed [DEPTH];
    logic [1:0]       e_lo     [DEPTH];
    logic [31:0]      e_data   [DEPTH];
    logic [DEPTH-1:0] e_done;

    logic [PW-1:0] tail_q, fill_q, head_q;
    logic [CW-1:0] count_q;

    logic        full;
    logic        can_fill;
    logic        do_fill;
    logic        do_push;
    logic        do_pop;
    logic        byp;
    logic [31:0] fill_fmt;

    function automatic logic [31:0] fmt(
        input logic [1:0]  size,
        input logic        sgn,
        input logic [1:0]  lo,
        input logic [31:0] d
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[{lo, 3'b000} +: 8];
        h = lo[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    // Queue status, fill/push/pop decisions and formatting of returning data
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        can_fill = (fill_q != tail_q) || (full && !e_done[fill_q]);
        do_fill  = dmem_rvalid && can_fill;
        do_push  = ld_valid && !full;
        fill_fmt = fmt(e_size[fill_q], e_signed[fill_q],
                       e_lo[fill_q], dmem_rdata);
`ifdef CPU_READPATH_BYPASS_EN
        byp      = do_fill && !e_done[head_q] && (fill_q == head_q);
`else
        byp      = 1'b0;
`endif
        do_pop   = mem_ready && (e_done[head_q] || byp);
    end

    // Head result to COM; zero when nothing is ready so a write hits x0
    always_comb begin
        mem_dest   = 5'd0;
        mem_result = 32'd0;
        if (e_done[head_q]) begin
            mem_dest   = e_dest[head_q];
            mem_result = e_data[head_q];
        end else if (byp) begin
            mem_dest   = e_dest[head_q];
            mem_result = fill_fmt;
        end
    end

    assign ld_full     = full;
    assign mem_pending = (count_q != '0);

    // Pointers, occupancy and done flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tail_q  <= '0;
            fill_q  <= '0;
            head_q  <= '0;
            count_q <= '0;
            e_done  <= '0;
        end else begin
            if (do_push) begin
                e_done[tail_q] <= 1'b0;
                tail_q         <= tail_q + 1'b1;
            end
            if (do_fill) begin
                if (!(byp && do_pop))
                    e_done[fill_q] <= 1'b1;
                fill_q <= fill_q + 1'b1;
            end
            if (do_pop) begin
                e_done[head_q] <= 1'b0;
                head_q         <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry payload: load attributes at issue, formatted data at return
    always_ff @(posedge clock) begin
        if (do_push) begin
            e_dest[tail_q]   <= ld_dest;
            e_size[tail_q]   <= ld_size;
            e_signed[tail_q] <= ld_signed;
            e_lo[tail_q]     <= ld_addr_lo;
        end
        if (do_fill)
            e_data[fill_q] <= fill_fmt;
    end

endmodule

// File: tb/tb_cpu_readpath.sv
// tb_cpu_readpath: directed and randomized checks of cpu_readpath
// against a queue-based reference model.
module tb_cpu_readpath;

    localparam int DEPTH = 4;
`ifdef CPU_READPATH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        ld_valid;
    logic [4:0]  ld_dest;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic [1:0]  ld_addr_lo;
    logic        ld_full;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_ready;
    logic [4:0]  mem_dest;
    logic [31:0] mem_result;
    logic        mem_pending;

    int checks = 0;
    int errors = 0;

    cpu_readpath #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_size(ld_size),
        .ld_signed(ld_signed), .ld_addr_lo(ld_addr_lo), .ld_full(ld_full),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_ready(mem_ready), .mem_dest(mem_dest),
        .mem_result(mem_result), .mem_pending(mem_pending)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [4:0]  dest;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  lo;
        bit          done;
        logic [31:0] res;
    } ent_t;

    ent_t q[$];

    function automatic logic [31:0] ref_fmt(input logic [1:0] size,
                                            input logic sgn,
                                            input logic [1:0] lo,
                                            input logic [31:0] d);
        int w, sh;
        logic [31:0] v, mask;
        if (size == 2'd0) begin
            w = 8; sh = 8 * int'(lo);
        end else if (size == 2'd1) begin
            w = 16; sh = (lo >= 2'd2) ? 16 : 0;
        end else begin
            w = 32; sh = 0;
        end
        v = d >> sh;
        if (w < 32) begin
            mask = (32'd1 << w) - 32'd1;
            v = v & mask;
            if (sgn && v[w-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic void model_out(output logic [4:0] d,
                                      output logic [31:0] r);
        d = 5'd0;
        r = 32'd0;
        if (q.size() > 0) begin
            if (q[0].done) begin
                d = q[0].dest;
                r = q[0].res;
            end else if (BYP && dmem_rvalid) begin
                d = q[0].dest;
                r = ref_fmt(q[0].size, q[0].sgn, q[0].lo, dmem_rdata);
            end
        end
    endfunction

    function automatic void model_step();
        int fi;
        bit full_pre, pop, byp_pre;
        ent_t e;
        fi = -1;
        for (int i = 0; i < q.size(); i++)
            if (!q[i].done && fi < 0) fi = i;
        full_pre = (q.size() == DEPTH);
        byp_pre  = BYP && dmem_rvalid && (fi == 0);
        pop = mem_ready && q.size() > 0 && (q[0].done || byp_pre);
        if (dmem_rvalid && fi >= 0) begin
            q[fi].done = 1'b1;
            q[fi].res  = ref_fmt(q[fi].size, q[fi].sgn, q[fi].lo, dmem_rdata);
        end
        if (pop) void'(q.pop_front());
        if (ld_valid && !full_pre) begin
            e.dest = ld_dest; e.size = ld_size; e.sgn = ld_signed;
            e.lo = ld_addr_lo; e.done = 1'b0; e.res = 32'd0;
            q.push_back(e);
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        ld_valid = 0; ld_dest = 0; ld_size = 0; ld_signed = 0;
        ld_addr_lo = 0; dmem_rvalid = 0; dmem_rdata = 0; mem_ready = 0;
    endtask

    task automatic issue(input logic [4:0] d, input logic [1:0] sz,
                         input logic sg, input logic [1:0] lo);
        ld_valid = 1; ld_dest = d; ld_size = sz;
        ld_signed = sg; ld_addr_lo = lo;
        tick();
        ld_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        checks++;
        if ({ld_full, mem_pending, mem_dest, mem_result} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs got full=%b pend=%b dest=%0d res=%h exp all 0",
                     ld_full, mem_pending, mem_dest, mem_result);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_byte();
        logic [31:0] exp_r [4];
        exp_r[0] = 32'h00000001; exp_r[1] = 32'h0000007F;
        exp_r[2] = 32'hFFFFFFFF; exp_r[3] = 32'hFFFFFF80;
        for (int i = 0; i < 4; i++) issue(5'd5, 2'd0, 1'b1, 2'(i));
        mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            dmem_rvalid = 1; dmem_rdata = 32'h80FF7F01;
            #1;
            checks++;
            if (i == 0) begin
                if (mem_dest !== 5'd0 || mem_result !== 32'd0) begin
                    errors++;
                    $display("FAIL byte_latency got dest=%0d res=%h exp 0/0",
                             mem_dest, mem_result);
                end
            end else if (mem_dest !== 5'd5 || mem_result !== exp_r[i-1]) begin
                errors++;
                $display("FAIL byte_%0d got dest=%0d res=%h exp 5/%h",
                         i - 1, mem_dest, mem_result, exp_r[i-1]);
            end
            tick();
        end
        dmem_rvalid = 0;
        #1;
        checks++;
        if (mem_dest !== 5'd5 || mem_result !== exp_r[3]) begin
            errors++;
            $display("FAIL byte_3 got dest=%0d res=%h exp 5/%h",
                     mem_dest, mem_result, exp_r[3]);
        end
        tick();
        #1;
        checks++;
        if (mem_dest !== 5'd0 || mem_pending !== 1'b0) begin
            errors++;
            $display("FAIL byte_drain got dest=%0d pend=%b exp 0/0",
                     mem_dest, mem_pending);
        end
        mem_ready = 0;
    endtask

    task automatic test_half();
        issue(5'd9, 2'd1, 1'b0, 2'd2);
        issue(5'd9, 2'd1, 1'b1, 2'd3);
        dmem_rvalid = 1; dmem_rdata = 32'hBEEF1234;
        tick();
        tick();
        dmem_rvalid = 0;
        #1;
        checks++;
        if (mem_dest !== 5'd9 || mem_result !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL half_unsigned got dest=%0d res=%h exp 9/0000beef",
                     mem_dest, mem_result);
        end
        mem_ready = 1;
        tick();
        #1;
        checks++;
        if (mem_dest !== 5'd9 || mem_result !== 32'hFFFFBEEF) begin
            errors++;
            $display("FAIL half_signed got dest=%0d res=%h exp 9/ffffbeef",
                     mem_dest, mem_result);
        end
        tick();
        mem_ready = 0;
    endtask

    task automatic test_full();
        logic [31:0] data [4];
        for (int i = 0; i < 4; i++) issue(5'(i + 1), 2'd2, 1'b0, 2'd0);
        #1;
        checks++;
        if (ld_full !== 1'b1 || mem_pending !== 1'b1) begin
            errors++;
            $display("FAIL full_flags got full=%b pend=%b exp 1/1",
                     ld_full, mem_pending);
        end
        issue(5'd31, 2'd2, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            data[i] = $urandom;
            dmem_rvalid = 1; dmem_rdata = data[i];
            tick();
        end
        dmem_rvalid = 0;
        #1;
        checks++;
        if (mem_dest !== 5'd1 || mem_result !== data[0] || ld_full !== 1'b1) begin
            errors++;
            $display("FAIL full_hold got dest=%0d res=%h full=%b exp 1/%h/1",
                     mem_dest, mem_result, ld_full, data[0]);
        end
        mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (mem_dest !== 5'(i + 1) || mem_result !== data[i]) begin
                errors++;
                $display("FAIL full_drain_%0d got dest=%0d res=%h exp %0d/%h",
                         i, mem_dest, mem_result, i + 1, data[i]);
            end
            tick();
        end
        #1;
        checks++;
        if (mem_dest !== 5'd0 || mem_pending !== 1'b0 || ld_full !== 1'b0) begin
            errors++;
            $display("FAIL full_empty got dest=%0d pend=%b full=%b exp 0/0/0",
                     mem_dest, mem_pending, ld_full);
        end
        mem_ready = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        d = $urandom;
        issue(5'd7, 2'd2, 1'b0, 2'd0);
        dmem_rvalid = 1; dmem_rdata = d;
        tick();
        dmem_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_dest !== 5'd7 || mem_result !== d) begin
                errors++;
                $display("FAIL bp_hold_%0d got dest=%0d res=%h exp 7/%h",
                         i, mem_dest, mem_result, d);
            end
            tick();
        end
        mem_ready = 1;
        tick();
        mem_ready = 0;
        #1;
        checks++;
        if (mem_dest !== 5'd0 || mem_pending !== 1'b0) begin
            errors++;
            $display("FAIL bp_pop got dest=%0d pend=%b exp 0/0",
                     mem_dest, mem_pending);
        end
    endtask

    task automatic test_stray();
        dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF; mem_ready = 1;
        tick();
        dmem_rvalid = 0; mem_ready = 0;
        #1;
        checks++;
        if (mem_dest !== 5'd0 || mem_result !== 32'd0 || mem_pending !== 1'b0) begin
            errors++;
            $display("FAIL stray got dest=%0d res=%h pend=%b exp 0/0/0",
                     mem_dest, mem_result, mem_pending);
        end
        issue(5'd12, 2'd0, 1'b0, 2'd1);
        dmem_rvalid = 1; dmem_rdata = 32'h0000A500;
        tick();
        dmem_rvalid = 0;
        #1;
        checks++;
        if (mem_dest !== 5'd12 || mem_result !== 32'h000000A5) begin
            errors++;
            $display("FAIL stray_next got dest=%0d res=%h exp 12/000000a5",
                     mem_dest, mem_result);
        end
        mem_ready = 1;
        tick();
        mem_ready = 0;
    endtask

    task automatic test_reset_mid();
        issue(5'd3, 2'd2, 1'b0, 2'd0);
        issue(5'd4, 2'd2, 1'b0, 2'd0);
        dmem_rvalid = 1; dmem_rdata = 32'h11111111;
        tick();
        tick();
        dmem_rvalid = 0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({ld_full, mem_pending, mem_dest, mem_result} !== 39'd0) begin
            errors++;
            $display("FAIL reset_mid got full=%b pend=%b dest=%0d res=%h exp all 0",
                     ld_full, mem_pending, mem_dest, mem_result);
        end
        q.delete();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [4:0]  ed;
        logic [31:0] er;
        for (int c = 0; c < 600; c++) begin
            ld_valid    = ($urandom_range(0, 99) < 50);
            ld_dest     = 5'($urandom);
            ld_size     = 2'($urandom);
            ld_signed   = 1'($urandom);
            ld_addr_lo  = 2'($urandom);
            dmem_rvalid = ($urandom_range(0, 99) < 45);
            dmem_rdata  = $urandom;
            mem_ready   = ($urandom_range(0, 99) < 55);
            #1;
            model_out(ed, er);
            checks++;
            if (mem_dest !== ed || mem_result !== er
                || ld_full !== (q.size() == DEPTH)
                || mem_pending !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_%0d got dest=%0d res=%h full=%b pend=%b exp %0d/%h/%b/%b",
                         c, mem_dest, mem_result, ld_full, mem_pending,
                         ed, er, q.size() == DEPTH, q.size() != 0);
            end
            tick();
        end
        idle_inputs();
        dmem_rvalid = 1; mem_ready = 1;
        for (int c = 0; c < 2 * DEPTH + 2; c++) tick();
        idle_inputs();
        #1;
        checks++;
        if (mem_pending !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain got pend=%b model=%0d exp 0/0",
                     mem_pending, q.size());
        end
    endtask

`ifdef CPU_READPATH_BYPASS_EN
    task automatic test_bypass();
        issue(5'd3, 2'd2, 1'b0, 2'd0);
        dmem_rvalid = 1; dmem_rdata = 32'h12345678; mem_ready = 1;
        #1;
        checks++;
        if (mem_dest !== 5'd3 || mem_result !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass got dest=%0d res=%h exp 3/12345678",
                     mem_dest, mem_result);
        end
        tick();
        dmem_rvalid = 0; mem_ready = 0;
        #1;
        checks++;
        if (mem_pending !== 1'b0 || mem_dest !== 5'd0) begin
            errors++;
            $display("FAIL bypass_pop got pend=%b dest=%0d exp 0/0",
                     mem_pending, mem_dest);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CPU_READPATH_BYPASS_EN
        test_bypass();
`else
        test_byte();
        test_half();
        test_full();
        test_backpressure();
`endif
        test_stray();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
